// File: rtl/jk_bank_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_ctrl_pkg
// Purpose  : Opcode and FSM state encodings shared by the JK bank controller,
//            its bus interface and the bench.
// Revision : 1.0 - initial release
// ============================================================================
package jk_bank_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_CLEAR      = 3'd1,
    OP_SET        = 3'd2,
    OP_LOAD       = 3'd3,
    OP_TOGGLE     = 3'd4,
    OP_COUNT_UP   = 3'd5,
    OP_COUNT_DOWN = 3'd6,
    OP_RSVD       = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/jk_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_ctrl_if
// Purpose  : Command/status bundle between a command source (master) and the
//            JK bank controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_steps;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_steps,
    input  cmd_ready, q, busy, done, wrap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_steps,
    output cmd_ready, q, busy, done, wrap
  );
endinterface
`default_nettype wire

// File: rtl/jk_bank_ctrl_cell.sv
`default_nettype none
// ============================================================================
// Module   : jk_cell
// Purpose  : Single JK flip-flop with clock enable and synchronous
//            active-low reset. Holds its value while E is low.
// Revision : 1.0 - initial release
// ============================================================================
module jk_cell (
  input  wire logic CLK,
  input  wire logic R,
  input  wire logic J,
  input  wire logic K,
  input  wire logic E,
  output logic      Q
);

  // Characteristic equation Q+ = J&~Q | ~K&Q, applied only when enabled
  always_ff @(posedge CLK) begin
    if (!R) begin
      Q <= 1'b0;
    end else if (E) begin
      Q <= (J & ~Q) | (~K & Q);
    end
  end

endmodule
`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_ctrl
// Purpose  : Command-driven sequencer for a bank of WIDTH JK cells. Decodes
//            clear/set/load/toggle into one-cycle J/K/E drive and runs a
//            multi-cycle synchronous counter for COUNT commands.
// Options  : JK_BANK_CTRL_DOWN_EN - when defined, opcode 6 is COUNT_DOWN;
//            otherwise it behaves as a reserved no-op.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input wire logic      CLK,
  input wire logic      R,
  jk_bank_ctrl_if.slave bus
);

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_remain;
  logic             r_wrap_flag;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;

  wire  [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_e;
  logic             w_chain;
  logic             w_wrap_now;
  logic             w_down;
  logic             w_is_count;

  // Direction of the running count; without the option only up-counting exists
`ifdef JK_BANK_CTRL_DOWN_EN
  assign w_down = (r_op == OP_COUNT_DOWN);
`else
  assign w_down = 1'b0;
`endif

  // Decide at accept time whether the command needs the counting state
  always_comb begin
    w_is_count = (bus.cmd_op == OP_COUNT_UP);
`ifdef JK_BANK_CTRL_DOWN_EN
    if (bus.cmd_op == OP_COUNT_DOWN) w_is_count = 1'b1;
`endif
    // A zero-step count has nothing to do and falls through as a no-op
    if (bus.cmd_steps == '0) w_is_count = 1'b0;
  end

  // Per-bit J/K/E drive from the latched command and current bank state
  always_comb begin
    w_e        = 1'b0;
    w_j        = '0;
    w_k        = '0;
    w_chain    = 1'b1;
    w_wrap_now = 1'b0;
    case (r_state)
      ST_APPLY: begin
        case (r_op)
          OP_CLEAR:  begin w_e = 1'b1; w_k = '1; end
          OP_SET:    begin w_e = 1'b1; w_j = '1; end
          OP_LOAD:   begin w_e = 1'b1; w_j = r_data; w_k = ~r_data; end
          OP_TOGGLE: begin w_e = 1'b1; w_j = r_data; w_k = r_data; end
          default:   ;
        endcase
      end
      ST_COUNT: begin
        w_e = 1'b1;
        // Ripple-free synchronous counter: a bit toggles when all lower bits
        // are 1 (up) or 0 (down). The final chain value flags a wrap.
        for (int i = 0; i < WIDTH; i++) begin
          w_j[i]  = w_chain;
          w_k[i]  = w_chain;
          w_chain = w_chain & (w_down ? ~w_q[i] : w_q[i]);
        end
        w_wrap_now = w_chain;
      end
      default: ;
    endcase
  end

  // Command FSM with operand latches, step counter and registered status
  always_ff @(posedge CLK) begin
    if (!R) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_data      <= '0;
      r_remain    <= '0;
      r_wrap_flag <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_op        <= op_t'(bus.cmd_op);
            r_data      <= bus.cmd_data;
            r_remain    <= bus.cmd_steps;
            r_wrap_flag <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= w_is_count ? ST_COUNT : ST_APPLY;
          end
        end
        ST_APPLY: begin
          r_done  <= 1'b1;
          r_wrap  <= 1'b0;
          r_state <= ST_DONE;
        end
        ST_COUNT: begin
          if (w_wrap_now) r_wrap_flag <= 1'b1;
          r_remain <= r_remain - CNT_W'(1);
          if (r_remain == CNT_W'(1)) begin
            r_done  <= 1'b1;
            r_wrap  <= r_wrap_flag | w_wrap_now;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_wrap  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
      jk_cell u_cell (
        .CLK (CLK),
        .R   (R),
        .J   (w_j[gi]),
        .K   (w_k[gi]),
        .E   (w_e),
        .Q   (w_q[gi])
      );
    end
  endgenerate

  assign bus.q         = w_q;
  assign bus.cmd_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_ctrl
// Purpose  : Self-checking bench for jk_bank_ctrl. Expected bank values,
//            wrap and done latency are queued when a command is driven and
//            compared when the controller reports completion.
// Options  : JK_BANK_CTRL_DOWN_EN selects the expected COUNT_DOWN behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_ctrl;
  import jk_bank_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic CLK = 1'b0;
  logic R   = 1'b0;
  always #5 CLK = ~CLK;

  jk_bank_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .R   (R),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] q;
    logic             wrap;
    int               lat;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             wrap;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a command, let it be accepted on the next edge, then wait for done
  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data,
                         input logic [CNT_W-1:0] steps, output int lat,
                         output logic [WIDTH-1:0] q_done, output logic wrap_done);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_steps = steps;
    tick();
    bus.cmd_valid = 1'b0;
    lat       = -1;
    q_done    = '0;
    wrap_done = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (bus.done) begin
        lat       = c;
        q_done    = bus.q;
        wrap_done = bus.wrap;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    R = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SET;
    bus.cmd_data  = '0;
    bus.cmd_steps = '0;
    tick();
    tick();
    checks++; if (bus.q !== 4'h0)      begin errors++; $display("FAIL reset_q got %h exp 0", bus.q); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.wrap !== 1'b0)   begin errors++; $display("FAIL reset_wrap got %b exp 0", bus.wrap); end
    R = 1'b1;
    sb.push_back('{4'hF, 1'b0, 1});
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL first_accept busy/ready got %b/%b exp 1/0", bus.busy, bus.cmd_ready);
    end
    tick();
    begin
      exp_t e = sb.pop_front();
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL first_set_done got %b exp 1", bus.done); end
      checks++; if (bus.q !== e.q) begin errors++; $display("FAIL first_set_q got %h exp %h", bus.q, e.q); end
    end
    tick();
  endtask

  // Runs a table of commands through the scoreboard
  task automatic test_load_toggle();
    vec_t tbl[2];
    int lat; logic [WIDTH-1:0] qd; logic wd;
    tbl[0] = '{OP_LOAD,   4'b1010, 8'd0, 4'b1010, 1'b0, 1};
    tbl[1] = '{OP_TOGGLE, 4'b0110, 8'd0, 4'b1100, 1'b0, 1};
    foreach (tbl[i]) begin
      exp_t e;
      sb.push_back('{tbl[i].q, tbl[i].wrap, tbl[i].lat});
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].steps, lat, qd, wd);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL lt_lat[%0d] got %0d exp %0d", i, lat, e.lat); end
      checks++; if (qd !== e.q)    begin errors++; $display("FAIL lt_q[%0d] got %h exp %h", i, qd, e.q); end
      checks++; if (wd !== e.wrap) begin errors++; $display("FAIL lt_wrap[%0d] got %b exp %b", i, wd, e.wrap); end
    end
  endtask

  task automatic test_count_wrap();
    int lat; logic [WIDTH-1:0] qd; logic wd;
    run_cmd(OP_LOAD, 4'hE, 8'd0, lat, qd, wd);
    checks++; if (qd !== 4'hE) begin errors++; $display("FAIL cw_load got %h exp e", qd); end
    // Each increment is checked on the cycle it lands
    sb.push_back('{4'hF, 1'b0, 1});
    sb.push_back('{4'h0, 1'b0, 2});
    sb.push_back('{4'h1, 1'b1, 3});
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_COUNT_UP; bus.cmd_steps = 8'd3;
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      exp_t e;
      tick();
      e = sb.pop_front();
      checks++; if (bus.q !== e.q) begin errors++; $display("FAIL cw_q[%0d] got %h exp %h", c, bus.q, e.q); end
      checks++; if (bus.done !== (c == 3)) begin errors++; $display("FAIL cw_done[%0d] got %b exp %b", c, bus.done, c == 3); end
      if (c == 3) begin
        checks++; if (bus.wrap !== e.wrap) begin errors++; $display("FAIL cw_wrap got %b exp %b", bus.wrap, e.wrap); end
      end
    end
    tick();
    // Non-wrapping count 1 -> 6
    sb.push_back('{4'h6, 1'b0, 5});
    run_cmd(OP_COUNT_UP, 4'h0, 8'd5, lat, qd, wd);
    begin
      exp_t e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL cu5_lat got %0d exp %0d", lat, e.lat); end
      checks++; if (qd !== e.q)    begin errors++; $display("FAIL cu5_q got %h exp %h", qd, e.q); end
      checks++; if (wd !== e.wrap) begin errors++; $display("FAIL cu5_wrap got %b exp %b", wd, e.wrap); end
    end
  endtask

  task automatic test_nop_cases();
    vec_t tbl[4];
    int lat; logic [WIDTH-1:0] qd; logic wd;
    tbl[0] = '{OP_LOAD,     4'b0101, 8'd0, 4'b0101, 1'b0, 1};
    tbl[1] = '{OP_COUNT_UP, 4'b1111, 8'd0, 4'b0101, 1'b0, 1};
    tbl[2] = '{OP_RSVD,     4'b1111, 8'd9, 4'b0101, 1'b0, 1};
    tbl[3] = '{OP_NOP,      4'b1111, 8'd4, 4'b0101, 1'b0, 1};
    foreach (tbl[i]) begin
      exp_t e;
      sb.push_back('{tbl[i].q, tbl[i].wrap, tbl[i].lat});
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].steps, lat, qd, wd);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL nop_lat[%0d] got %0d exp %0d", i, lat, e.lat); end
      checks++; if (qd !== e.q)    begin errors++; $display("FAIL nop_q[%0d] got %h exp %h", i, qd, e.q); end
      checks++; if (wd !== e.wrap) begin errors++; $display("FAIL nop_wrap[%0d] got %b exp %b", i, wd, e.wrap); end
    end
  endtask

  // cmd_valid held high across a command: operands change while busy
  task automatic test_back_to_back();
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_RSVD; bus.cmd_data = 4'h0; bus.cmd_steps = 8'd0;
    tick();
    bus.cmd_op = OP_SET;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.q !== 4'b0101) begin
      errors++; $display("FAIL b2b_first got done=%b q=%h exp done=1 q=5", bus.done, bus.q);
    end
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got ready=%b busy=%b done=%b exp 1/0/0", bus.cmd_ready, bus.busy, bus.done);
    end
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept busy got %b exp 1", bus.busy); end
    bus.cmd_valid = 1'b0;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.q !== 4'hF) begin
      errors++; $display("FAIL b2b_second got done=%b q=%h exp done=1 q=f", bus.done, bus.q);
    end
    tick();
  endtask

  task automatic test_abort();
    int lat; logic [WIDTH-1:0] qd; logic wd;
    logic saw_done;
    run_cmd(OP_CLEAR, 4'h0, 8'd0, lat, qd, wd);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_COUNT_UP; bus.cmd_steps = 8'd10;
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) sb.push_back('{4'(c), 1'b0, c});
    for (int c = 1; c <= 4; c++) begin
      exp_t e;
      tick();
      e = sb.pop_front();
      checks++; if (bus.q !== e.q) begin errors++; $display("FAIL abort_inc[%0d] got %h exp %h", c, bus.q, e.q); end
    end
    R = 1'b0;
    tick();
    checks++; if (bus.q !== 4'h0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_state got q=%h done=%b ready=%b busy=%b exp 0/0/1/0",
                         bus.q, bus.done, bus.cmd_ready, bus.busy);
    end
    R = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0 || bus.q !== 4'h0) begin
      errors++; $display("FAIL abort_quiet got done_seen=%b q=%h exp 0/0", saw_done, bus.q);
    end
  endtask

  task automatic test_down();
    int lat; logic [WIDTH-1:0] qd; logic wd;
    exp_t e;
    run_cmd(OP_LOAD, 4'h1, 8'd0, lat, qd, wd);
`ifdef JK_BANK_CTRL_DOWN_EN
    sb.push_back('{4'hF, 1'b1, 2});
`else
    sb.push_back('{4'h1, 1'b0, 1});
`endif
    run_cmd(OP_COUNT_DOWN, 4'h0, 8'd2, lat, qd, wd);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL down_lat got %0d exp %0d", lat, e.lat); end
    checks++; if (qd !== e.q)    begin errors++; $display("FAIL down_q got %h exp %h", qd, e.q); end
    checks++; if (wd !== e.wrap) begin errors++; $display("FAIL down_wrap got %b exp %b", wd, e.wrap); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = '0;
    bus.cmd_steps = '0;
    test_reset();
    test_load_toggle();
    test_count_wrap();
    test_nop_cases();
    test_back_to_back();
    test_abort();
    test_down();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command-driven controller that sequences a bank of WIDTH JK flip-flop cells, each with enable and reset. It decodes a small command set (clear, set, load, toggle, multi-step count) into per-bit J/K/enable drive. It shares the bank between single-cycle bit operations and a multi-cycle synchronous counter mode. It sits between a lab-level command source (switches/FSM) and the JK register bank whose outputs drive displays.

## Interface
- WIDTH, 4, number of JK cells in the bank
- CNT_W, 8, width of the step counter for count commands
- CLK  in  1  clock, all state updates on rising edge
- R  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command; high only in IDLE
- cmd_op  in  3  opcode: 0 NOP, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 COUNT_UP, 6 COUNT_DOWN, 7 reserved
- cmd_data  in  WIDTH  LOAD value / TOGGLE mask
- cmd_steps  in  CNT_W  increment/decrement count for COUNT ops
- q  out  WIDTH  bank state (JK cell outputs)
- busy  out  1  command in progress (not IDLE)
- done  out  1  one-cycle pulse, command completed
- wrap  out  1  valid with done: at least one wrap-around occurred during the command

## Operation
- States: IDLE, APPLY, COUNT, DONE. Encoding 2 bits.
- IDLE: cmd_ready=1. Accept when cmd_valid && cmd_ready at an edge; latch op, data, steps.
- Accept → APPLY for ops 0–4 and 7; → COUNT for ops 5/6 with steps≠0; steps=0 → APPLY treated as NOP.
- APPLY drive, all bits E=1: CLEAR J=0,K=1; SET J=1,K=0; LOAD J=d,K=~d; TOGGLE J=K=mask; NOP/reserved E=0. Next: DONE.
- COUNT_UP: bit i J=K=AND(q[i-1:0]), bit 0 J=K=1; one increment per cycle; remaining decremented each edge; at remaining=1 edge → DONE.
- COUNT_DOWN: bit i J=K=AND(~q[i-1:0]).
- Wrap: set internal flag when COUNT_UP increments all-ones→0 or COUNT_DOWN decrements 0→all-ones; flag cleared on accept.
- DONE: done=1, wrap=flag, q stable; next edge → IDLE.
- Outside APPLY/COUNT all cells E=0 (hold).
- cmd_valid while busy ignored; latched operands unaffected by input changes.
- Reset (R=0 at edge), overriding everything incl. mid-command: q=0, state IDLE, flag=0. No done is produced for an aborted command.
- Reset values: q=0, cmd_ready=1, busy=0, done=0, wrap=0.

## Timing
- Accept at edge e0; busy=1 and cmd_ready=0 from e0.
- Single ops: q updates at e1; done=1 in cycle e1–e2 with new q; cmd_ready=1 after e2. Throughput one command per 3 cycles.
- COUNT n: q changes at e1..en; done in cycle en–en+1; cmd_ready=1 after en+1.
- done and wrap are registered-state outputs, no combinational path from cmd_* to them; cmd_ready depends only on state.

## Configuration
- JK_BANK_CTRL_DOWN_EN defined: op 6 is COUNT_DOWN as above.
- Undefined: op 6 decodes as reserved (NOP, APPLY path, done after 2 edges, q unchanged, wrap=0); down-count logic not synthesized.

## Structure
- Package jk_bank_ctrl_pkg: opcode constants OP_NOP…OP_RSVD, state constants ST_IDLE/ST_APPLY/ST_COUNT/ST_DONE.
- Sub-module jk_cell: one JK flip-flop with enable, synchronous active-low reset (Q<=J&~Q | ~K&Q when E); WIDTH instances via generate.
- Controller holds FSM, operand latches, step counter, wrap flag, J/K/E decode.

## Test plan
- Reset with cmd_valid=1, op=SET: q=0, cmd_ready=1, busy=0, done=0; first edge with R=1 accepts SET.
- LOAD 4'b1010 then TOGGLE 4'b0110: q=1010 with done 2 edges after first accept, then q=1100, wrap=0.
- q=4'hE, COUNT_UP steps=3: q E→F→0→1 on consecutive edges, done on 4th cycle after accept, wrap=1.
- COUNT_UP steps=0 and op 7: q unchanged, done 2 edges after accept, wrap=0; cmd_valid held during busy not re-accepted until cmd_ready.
- q=0, COUNT_UP steps=10, drop R after 4 increments: q=0, no done pulse, cmd_ready=1 next cycle.
- Macro defined: q=1, COUNT_DOWN steps=2 → 0 then F, wrap=1; macro undefined: same command leaves q=1, wrap=0.
